// File: rtl/uart_tx_cfg_if.sv
// Frame request handshake between a byte source and uart_tx_cfg: payload, line
// configuration and the valid/ready pair.
interface uart_tx_cfg_if #(
   parameter int unsigned DATA_W = 8
);
   logic              i_TX_DV;
   logic [DATA_W-1:0] i_TX_Byte;
   logic [1:0]        i_Cfg_Len;
   logic [1:0]        i_Cfg_Par;
   logic              i_Cfg_Stop;
   logic              o_TX_Ready;

   modport master (
      output i_TX_DV, i_TX_Byte, i_Cfg_Len, i_Cfg_Par, i_Cfg_Stop,
      input  o_TX_Ready
   );

   modport slave (
      input  i_TX_DV, i_TX_Byte, i_Cfg_Len, i_Cfg_Par, i_Cfg_Stop,
      output o_TX_Ready
   );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5-8 data bits, none/odd/even parity, 1 or 2 stop bits.
// Optional line-break generation is compiled in when UART_TX_BREAK_EN is defined.
module uart_tx_cfg #(
   parameter int unsigned CLK_FREQ  = 25000000,
   parameter int unsigned BAUD_RATE = 115200,
   parameter int unsigned DATA_W    = 8
) (
   input  logic          i_Clock,
   input  logic          i_Rst_L,
`ifdef UART_TX_BREAK_EN
   input  logic          i_Break,
`endif
   uart_tx_cfg_if.slave  tx_if,
   output logic          o_TX_Active,
   output logic          o_TX_Serial,
   output logic          o_TX_Done
);
   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;
   localparam int unsigned IDX_W        = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
      ,
      S_BREAK  = 3'd5,
      S_MARK   = 3'd6
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
   logic                stop2_q, stop2_d;
   logic [DATA_W-1:0]   byte_q, byte_d;
   logic [1:0]          len_q, len_d;
   logic [1:0]          par_q, par_d;
   logic                stop_q, stop_d;
   logic                serial_q, serial_d;
   logic                ready_q, ready_d;
   logic                active_q, active_d;
   logic                done_q, done_d;

   logic                bit_tick;
   logic [CNT_W-1:0]    cnt_inc;
   logic [IDX_W-1:0]    next_idx;
   logic [IDX_W-1:0]    last_idx;
   logic [DATA_W-1:0]   data_mask;
   logic                par_en;
   logic                par_bit;

   assign bit_tick  = (bit_cnt_q == CNT_LAST);
   assign cnt_inc   = CNT_W'(bit_cnt_q + 1'b1);
   assign next_idx  = IDX_W'(bit_idx_q + 1'b1);
   assign last_idx  = IDX_W'(4) + IDX_W'(len_q);
   // Only the bits actually sent feed the parity.
   assign data_mask = {DATA_W{1'b1}} >> (IDX_W'(DATA_W - 1) - last_idx);
   assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
   assign par_bit   = (^(byte_q & data_mask)) ^ (par_q == 2'b01);

   // State and registered outputs
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         stop2_q   <= 1'b0;
         byte_q    <= '0;
         len_q     <= '0;
         par_q     <= '0;
         stop_q    <= 1'b0;
         serial_q  <= 1'b1;
         ready_q   <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         stop2_q   <= stop2_d;
         byte_q    <= byte_d;
         len_q     <= len_d;
         par_q     <= par_d;
         stop_q    <= stop_d;
         serial_q  <= serial_d;
         ready_q   <= ready_d;
         active_q  <= active_d;
         done_q    <= done_d;
      end
   end

   // Next state and next output values
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      bit_idx_d = bit_idx_q;
      stop2_d   = stop2_q;
      byte_d    = byte_q;
      len_d     = len_q;
      par_d     = par_q;
      stop_d    = stop_q;
      serial_d  = serial_q;
      ready_d   = ready_q;
      active_d  = active_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            serial_d  = 1'b1;
            ready_d   = 1'b1;
            active_d  = 1'b0;
            bit_cnt_d = '0;
            bit_idx_d = '0;
`ifdef UART_TX_BREAK_EN
            if (i_Break) begin
               serial_d = 1'b0;
               ready_d  = 1'b0;
               active_d = 1'b1;
               state_d  = S_BREAK;
            end else
`endif
            if (tx_if.i_TX_DV) begin
               byte_d   = tx_if.i_TX_Byte;
               len_d    = tx_if.i_Cfg_Len;
               par_d    = tx_if.i_Cfg_Par;
               stop_d   = tx_if.i_Cfg_Stop;
               serial_d = 1'b0;
               ready_d  = 1'b0;
               active_d = 1'b1;
               state_d  = S_START;
            end
         end
         S_START: begin
            bit_cnt_d = cnt_inc;
            if (bit_tick) begin
               bit_cnt_d = '0;
               bit_idx_d = '0;
               serial_d  = byte_q[0];
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            bit_cnt_d = cnt_inc;
            if (bit_tick) begin
               bit_cnt_d = '0;
               if (bit_idx_q == last_idx) begin
                  if (par_en) begin
                     serial_d = par_bit;
                     state_d  = S_PARITY;
                  end else begin
                     serial_d = 1'b1;
                     stop2_d  = stop_q;
                     state_d  = S_STOP;
                  end
               end else begin
                  bit_idx_d = next_idx;
                  serial_d  = byte_q[next_idx];
               end
            end
         end
         S_PARITY: begin
            bit_cnt_d = cnt_inc;
            if (bit_tick) begin
               bit_cnt_d = '0;
               serial_d  = 1'b1;
               stop2_d   = stop_q;
               state_d   = S_STOP;
            end
         end
         S_STOP: begin
            bit_cnt_d = cnt_inc;
            if (bit_tick) begin
               bit_cnt_d = '0;
               if (stop2_q) begin
                  stop2_d = 1'b0;
               end else begin
                  done_d   = 1'b1;
                  active_d = 1'b0;
                  ready_d  = 1'b1;
                  state_d  = S_IDLE;
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         S_BREAK: begin
            if (!i_Break) begin
               serial_d  = 1'b1;
               bit_cnt_d = '0;
               state_d   = S_MARK;
            end
         end
         // Mark-after-break: one bit time high, then ready without a Done pulse.
         S_MARK: begin
            bit_cnt_d = cnt_inc;
            if (bit_tick) begin
               bit_cnt_d = '0;
               ready_d   = 1'b1;
               active_d  = 1'b0;
               state_d   = S_IDLE;
            end
         end
`endif
         default: begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            bit_idx_d = '0;
            stop2_d   = 1'b0;
            serial_d  = 1'b1;
            ready_d   = 1'b1;
            active_d  = 1'b0;
         end
      endcase
   end

   assign tx_if.o_TX_Ready = ready_q;
   assign o_TX_Active      = active_q;
   assign o_TX_Serial      = serial_q;
   assign o_TX_Done        = done_q;
endmodule
